// File: rtl/control_unit_pkg.sv
// Shared RV32I decode constants: opcodes, funct fields, ALU op codes and
// the datapath select encodings used by the main decoder.
package control_unit_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_JALR    = 3'b000;

    // ALU operation = {instr[30], funct3}
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_DMEM = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    // Format 11 is B or J depending on which of branch/jump is set
    typedef enum logic [1:0] {
        IMM_I  = 2'b00,
        IMM_S  = 2'b01,
        IMM_U  = 2'b10,
        IMM_BJ = 2'b11
    } imm_fmt_e;

    typedef enum logic [1:0] {
        RW_BYTE = 2'b00,
        RW_HALF = 2'b01,
        RW_WORD = 2'b10
    } rw_mode_e;

    typedef struct packed {
        logic       alu_pc_select;
        logic       alu_mux1_select;
        logic       alu_imm_select;
        logic [1:0] alu_mux2_select;
        logic [3:0] alu_op_select;
        logic [1:0] rf_w_select;
        logic       w_en_rf;
        logic       wr_en_dmem;
        logic [1:0] rw_mode;
        logic       branch;
        logic       jump;
    } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Instruction-in / control-out bundle between the fetch stage and the decoder.
interface control_unit_if;
    logic [31:0] instr;
    logic        alu_pc_select;
    logic        alu_mux1_select;
    logic        alu_imm_select;
    logic [1:0]  alu_mux2_select;
    logic [3:0]  alu_op_select;
    logic [1:0]  rf_w_select;
    logic        w_en_rf;
    logic        w_en_pmem;
    logic        wr_en_dmem;
    logic [1:0]  rw_mode;
    logic        branch;
    logic        jump;

    modport master (
        output instr,
        input  alu_pc_select, alu_mux1_select, alu_imm_select, alu_mux2_select,
               alu_op_select, rf_w_select, w_en_rf, w_en_pmem, wr_en_dmem,
               rw_mode, branch, jump
    );

    modport slave (
        input  instr,
        output alu_pc_select, alu_mux1_select, alu_imm_select, alu_mux2_select,
               alu_op_select, rf_w_select, w_en_rf, w_en_pmem, wr_en_dmem,
               rw_mode, branch, jump
    );
endinterface

// File: rtl/control_unit_decode.sv
// Purely combinational RV32I main decoder; any invalid opcode or funct
// combination collapses the whole control word to zero (NOP).
module control_decode
    import control_unit_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       valid;
    ctrl_t      c;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register indices and immediate bits are consumed by the datapath, not here
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        c     = '0;
        valid = 1'b1;
        case (opcode)
            OP_REG: begin
                valid = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));
                c.alu_op_select = {instr[30], funct3};
                c.rf_w_select   = WB_ALU;
                c.w_en_rf       = 1'b1;
            end
            OP_IMM: begin
                // Only shift-right uses bit30 (SRAI); ADDI has no SUB form
                c.alu_op_select   = (funct3 == F3_SR) ? {instr[30], funct3} : {1'b0, funct3};
                c.alu_imm_select  = 1'b1;
                c.alu_mux2_select = IMM_I;
                c.rf_w_select     = WB_ALU;
                c.w_en_rf         = 1'b1;
            end
            OP_LOAD: begin
                valid = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                        (funct3 == F3_LBU) || (funct3 == F3_LHU);
                c.alu_op_select   = ALU_ADD;
                c.alu_imm_select  = 1'b1;
                c.alu_mux2_select = IMM_I;
                c.rf_w_select     = WB_DMEM;
                c.w_en_rf         = 1'b1;
                c.rw_mode         = funct3[1:0];
            end
            OP_STORE: begin
                valid = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW);
                c.alu_op_select   = ALU_ADD;
                c.alu_imm_select  = 1'b1;
                c.alu_mux2_select = IMM_S;
                c.wr_en_dmem      = 1'b1;
                c.rw_mode         = funct3[1:0];
            end
            OP_BRANCH: begin
                c.branch          = 1'b1;
                c.alu_mux2_select = IMM_BJ;
                case (funct3)
                    F3_BEQ, F3_BNE:   c.alu_op_select = ALU_SUB;
                    F3_BLT, F3_BGE:   c.alu_op_select = ALU_SLT;
                    F3_BLTU, F3_BGEU: c.alu_op_select = ALU_SLTU;
                    default:          valid = 1'b0;
                endcase
            end
            OP_JAL: begin
                c.jump            = 1'b1;
                c.alu_op_select   = ALU_ADD;
                c.alu_mux2_select = IMM_BJ;
                c.rf_w_select     = WB_PC4;
                c.w_en_rf         = 1'b1;
            end
            OP_JALR: begin
                valid = (funct3 == F3_JALR);
                c.jump            = 1'b1;
                c.alu_op_select   = ALU_ADD;
                c.alu_imm_select  = 1'b1;
                c.alu_mux2_select = IMM_I;
                c.rf_w_select     = WB_PC4;
                c.w_en_rf         = 1'b1;
            end
            OP_LUI: begin
                c.alu_mux1_select = 1'b1;
                c.alu_imm_select  = 1'b1;
                c.alu_mux2_select = IMM_U;
                c.alu_op_select   = ALU_ADD;
                c.rf_w_select     = WB_ALU;
                c.w_en_rf         = 1'b1;
            end
            OP_AUIPC: begin
                c.alu_pc_select   = 1'b1;
                c.alu_imm_select  = 1'b1;
                c.alu_mux2_select = IMM_U;
                c.alu_op_select   = ALU_ADD;
                c.rf_w_select     = WB_ALU;
                c.w_en_rf         = 1'b1;
            end
            default: valid = 1'b0;
        endcase
        ctrl = valid ? c : '0;
    end

endmodule

// File: rtl/control_unit.sv
// RV32I main decoder with a single output register; reset forces a NOP
// control word and the first decode appears one edge after release.
module control_unit
    import control_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    control_unit_if.slave bus
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .instr (bus.instr),
        .ctrl  (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.alu_pc_select   = ctrl_q.alu_pc_select;
    assign bus.alu_mux1_select = ctrl_q.alu_mux1_select;
    assign bus.alu_imm_select  = ctrl_q.alu_imm_select;
    assign bus.alu_mux2_select = ctrl_q.alu_mux2_select;
    assign bus.alu_op_select   = ctrl_q.alu_op_select;
    assign bus.rf_w_select     = ctrl_q.rf_w_select;
    assign bus.w_en_rf         = ctrl_q.w_en_rf;
    assign bus.wr_en_dmem      = ctrl_q.wr_en_dmem;
    assign bus.rw_mode         = ctrl_q.rw_mode;
    assign bus.branch          = ctrl_q.branch;
    assign bus.jump            = ctrl_q.jump;
    // Program memory is written only by the loader
    assign bus.w_en_pmem       = 1'b0;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit with hand-computed control words.
module tb_control_unit;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_errors;

    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word: {pc,mux1,imm,mux2[1:0],op[3:0],rfw[1:0],wen_rf,pmem,dmem,rw[1:0],br,j}
    function automatic logic [18:0] observed();
        return {bus.alu_pc_select, bus.alu_mux1_select, bus.alu_imm_select,
                bus.alu_mux2_select, bus.alu_op_select, bus.rf_w_select,
                bus.w_en_rf, bus.w_en_pmem, bus.wr_en_dmem, bus.rw_mode,
                bus.branch, bus.jump};
    endfunction

    function automatic logic [18:0] mk(input logic pc, input logic m1, input logic imm,
                                       input logic [1:0] m2, input logic [3:0] op,
                                       input logic [1:0] rfw, input logic wen,
                                       input logic dm, input logic [1:0] rw,
                                       input logic br, input logic j);
        return {pc, m1, imm, m2, op, rfw, wen, 1'b0, dm, rw, br, j};
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] instr, input logic [18:0] exp);
        @(negedge clk);
        bus.instr = instr;
        @(posedge clk);
        #1;
        check(tag, observed(), exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.instr = 32'h00418133;

        @(posedge clk); #1;
        check("reset_edge1", observed(), '0);
        @(posedge clk); #1;
        check("reset_edge2", observed(), '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("add_after_reset", observed(), mk(0,0,0,2'b00,4'b0000,2'b00,1,0,2'b00,0,0));

        run("addi",   32'h00418113, mk(0,0,1,2'b00,4'b0000,2'b00,1,0,2'b00,0,0));
        run("lw",     32'h00822183, mk(0,0,1,2'b00,4'b0000,2'b01,1,0,2'b10,0,0));
        run("sw",     32'h00322623, mk(0,0,1,2'b01,4'b0000,2'b00,0,1,2'b10,0,0));
        run("bge",    32'h0041D663, mk(0,0,0,2'b11,4'b0010,2'b00,0,0,2'b00,1,0));
        run("jal",    32'h050001EF, mk(0,0,0,2'b11,4'b0000,2'b10,1,0,2'b00,0,1));
        run("lui",    32'h00002537, mk(0,1,1,2'b10,4'b0000,2'b00,1,0,2'b00,0,0));
        run("add",    32'h00418133, mk(0,0,0,2'b00,4'b0000,2'b00,1,0,2'b00,0,0));
        run("zero",   32'h00000000, '0);
        run("sub",    32'h40418133, mk(0,0,0,2'b00,4'b1000,2'b00,1,0,2'b00,0,0));
        run("sra",    32'h40415133, mk(0,0,0,2'b00,4'b1101,2'b00,1,0,2'b00,0,0));
        run("r_bad7", 32'h40419133, '0);
        run("mul",    32'h02418133, '0);
        run("srai",   32'h40415113, mk(0,0,1,2'b00,4'b1101,2'b00,1,0,2'b00,0,0));
        run("sltiu",  32'h0041B113, mk(0,0,1,2'b00,4'b0011,2'b00,1,0,2'b00,0,0));
        run("auipc",  32'h00000517, mk(1,0,1,2'b10,4'b0000,2'b00,1,0,2'b00,0,0));
        run("jalr",   32'h000100E7, mk(0,0,1,2'b00,4'b0000,2'b10,1,0,2'b00,0,1));
        run("jalr_bad", 32'h000110E7, '0);
        run("lbu",    32'h00824183, mk(0,0,1,2'b00,4'b0000,2'b01,1,0,2'b00,0,0));
        run("lh",     32'h00821183, mk(0,0,1,2'b00,4'b0000,2'b01,1,0,2'b01,0,0));
        run("ld_bad", 32'h00823183, '0);
        run("st_bad", 32'h00324623, '0);
        run("bltu",   32'h0041E663, mk(0,0,0,2'b11,4'b0011,2'b00,0,0,2'b00,1,0));
        run("beq",    32'h00418663, mk(0,0,0,2'b11,4'b1000,2'b00,0,0,2'b00,1,0));
        run("br_bad", 32'h0041A663, '0);
        run("fence",  32'h0000000F, '0);
        run("ecall",  32'h00000073, '0);

        // Reset arriving mid-stream overrides a valid decode
        run("lui2",   32'h00002537, mk(0,1,1,2'b10,4'b0000,2'b00,1,0,2'b00,0,0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset", observed(), '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_mid_reset", observed(), mk(0,1,1,2'b10,4'b0000,2'b00,1,0,2'b00,0,0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
